// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared types and constants for the sprite layer: screen geometry,
//   coordinate width and the 4-way facing direction used by the renderer.
package sprite_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

endpackage

// File: rtl/sprite_anim_ctr.sv
// sprite_anim_ctr
//   Animation sequencer. Counts frame_tick pulses while anim_en is high and
//   advances the animation frame once every FRAME_PERIOD counted ticks,
//   wrapping after NUM_FRAMES frames.
// Ports:
//   vga_clk    pixel clock
//   reset      synchronous, active-high
//   frame_tick one-cycle pulse at vblank start
//   anim_en    advance enable, qualified by frame_tick in the same cycle
//   anim_frame current animation frame
module sprite_anim_ctr #(
  parameter  int FRAME_PERIOD = 8,
  parameter  int NUM_FRAMES   = 4,
  localparam int FRAME_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               anim_en,
  output logic [FRAME_W-1:0] anim_frame
);

  // A period of 1 still needs a 1-bit counter; it simply never leaves 0.
  localparam int TICK_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

  logic [TICK_W-1:0] tick_cnt;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      tick_cnt   <= '0;
      anim_frame <= '0;
    end else if (frame_tick && anim_en) begin
      if (tick_cnt == TICK_W'(FRAME_PERIOD - 1)) begin
        tick_cnt <= '0;
        if (anim_frame == FRAME_W'(NUM_FRAMES - 1))
          anim_frame <= '0;
        else
          anim_frame <= anim_frame + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer
//   Per-sprite pixel engine. Tests the beam position against a latched
//   sprite box, rotates the local coordinate by the latched direction,
//   addresses an external synchronous sprite ROM and returns the palette
//   index plus an opaque flag, 3 cycles after the coordinate is presented.
// Ports:
//   vga_clk, reset            clock and synchronous active-high reset
//   DrawX, DrawY              current beam position
//   frame_tick                vblank pulse; latches attributes, steps animation
//   enable, pos_x, pos_y, dir sprite attributes (latched on frame_tick)
//   anim_en                   animation advance enable
//   rom_addr / rom_q          sprite ROM address out, data back one cycle later
//   pixel_idx, pixel_opaque   palette index and coverage for the pixel
//   anim_frame                current animation frame
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter  int SPRITE_S        = 32,
  parameter  int NUM_FRAMES      = 4,
  parameter  int FRAME_PERIOD    = 8,
  parameter  int IDX_W           = 2,
  parameter  int TRANSPARENT_IDX = 0,
  localparam int ADDR_W          = $clog2(NUM_FRAMES * SPRITE_S * SPRITE_S),
  localparam int FRAME_W         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [1:0]         dir,
  input  logic               anim_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pixel_idx,
  output logic               pixel_opaque,
  output logic [FRAME_W-1:0] anim_frame
);

  // One extra bit so box edges past the screen never wrap around.
  localparam int                 CW1   = COORD_W + 1;
  localparam logic [CW1-1:0]     S_MAX = CW1'(SPRITE_S - 1);
  localparam logic [CW1-1:0]     S_EXT = CW1'(SPRITE_S);

  // Attributes only move on frame_tick so a frame is drawn consistently.
  logic               en_q;
  logic [COORD_W-1:0] pos_x_q;
  logic [COORD_W-1:0] pos_y_q;
  dir_t               dir_q;

  logic [CW1-1:0]    x_ext, y_ext, px_ext, py_ext;
  logic [CW1-1:0]    lx, ly, u, v;
  logic              hit;
  logic [ADDR_W-1:0] addr_next;
  logic              hit1, hit2;

  sprite_anim_ctr #(
    .FRAME_PERIOD (FRAME_PERIOD),
    .NUM_FRAMES   (NUM_FRAMES)
  ) u_anim (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .anim_en    (anim_en),
    .anim_frame (anim_frame)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      dir_q   <= DIR_UP;
    end else if (frame_tick) begin
      en_q    <= enable;
      pos_x_q <= pos_x;
      pos_y_q <= pos_y;
      dir_q   <= dir_t'(dir);
    end
  end

  // Box test and rotation. Out-of-box lx/ly are garbage but masked by hit.
  always_comb begin
    x_ext  = {1'b0, DrawX};
    y_ext  = {1'b0, DrawY};
    px_ext = {1'b0, pos_x_q};
    py_ext = {1'b0, pos_y_q};
    lx     = x_ext - px_ext;
    ly     = y_ext - py_ext;
    hit    = en_q
             && (x_ext >= px_ext) && (x_ext < px_ext + S_EXT)
             && (y_ext >= py_ext) && (y_ext < py_ext + S_EXT);
    u = lx;
    v = ly;
    case (dir_q)
      DIR_UP:    begin u = lx;         v = ly;         end
      DIR_RIGHT: begin u = ly;         v = S_MAX - lx; end
      DIR_DOWN:  begin u = S_MAX - lx; v = S_MAX - ly; end
      DIR_LEFT:  begin u = S_MAX - ly; v = lx;         end
      default:   begin u = lx;         v = ly;         end
    endcase
    addr_next = '0;
    if (hit)
      addr_next = ADDR_W'(anim_frame) * ADDR_W'(SPRITE_S * SPRITE_S)
                + ADDR_W'(v) * ADDR_W'(SPRITE_S)
                + ADDR_W'(u);
  end

  // Three register stages: address, ROM read (hit2 tracks it), output.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr     <= '0;
      hit1         <= 1'b0;
      hit2         <= 1'b0;
      pixel_idx    <= '0;
      pixel_opaque <= 1'b0;
    end else begin
      rom_addr     <= addr_next;
      hit1         <= hit;
      hit2         <= hit1;
      pixel_idx    <= hit2 ? rom_q : '0;
      pixel_opaque <= hit2 && (rom_q != IDX_W'(TRANSPARENT_IDX));
    end
  end

endmodule
